// File: rtl/temporizador_regressivo_pkg.sv
// Shared state encoding and default parameters for the down-counting timer.
package temporizador_regressivo_pkg;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam int WIDTH_DEF    = 16;
    localparam int PRESCALE_DEF = 1;

    function automatic logic is_active(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_PAUSE);
    endfunction
endpackage

// File: rtl/temporizador_regressivo_if.sv
// Control/data bundle between the game FSM (master) and the timer (slave).
interface temporizador_regressivo_if #(parameter int WIDTH = 16);
    logic             carrega;
    logic             inicia;
    logic             pausa;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             ativo;
    logic             zero;
    logic             fim;

    modport master (output carrega, inicia, pausa, D,
                    input  Q, ativo, zero, fim);
    modport slave  (input  carrega, inicia, pausa, D,
                    output Q, ativo, zero, fim);
endinterface

// File: rtl/temporizador_regressivo_divisor_tick.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the wrapping cycle.
// o_tick is combinational so the owner can act on the same edge the counter wraps.
module divisor_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic clr,
    input  logic i_sclr,
    input  logic i_en,
    output logic o_tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;
    logic        w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && w_last;

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (i_sclr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/temporizador_regressivo.sv
// Loadable down-counting timer: IDLE/RUN/PAUSE/DONE FSM, Q register, one-cycle fim pulse.
// Load has one edge of latency; fim is high the cycle after the edge that reaches zero.
module temporizador_regressivo
    import temporizador_regressivo_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                       clock,
    input  logic                       clr,
    temporizador_regressivo_if.slave   bus
);
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_fim;

    logic w_sclr;
    logic w_en;
    logic w_tick;
    logic w_dec;

    divisor_tick #(.PRESCALE(PRESCALE)) u_div (
        .clock  (clock),
        .clr    (clr),
        .i_sclr (w_sclr),
        .i_en   (w_en),
        .o_tick (w_tick)
    );

    // Leaving PAUSE counts on the same edge, so each paused cycle costs exactly one.
    always_comb begin
        w_sclr = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            ST_IDLE:  w_sclr = bus.inicia;
            ST_RUN,
            ST_PAUSE: begin
                if (bus.carrega)     w_sclr = 1'b1;
                else if (!bus.pausa) w_en   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_dec = w_en && w_tick;

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_fim   <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.carrega) begin
                        r_q <= bus.D;
                        if (bus.inicia) begin
                            if (bus.D != '0) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_state <= ST_DONE;
                                r_fim   <= 1'b1;
                            end
                        end
                    end else if (bus.inicia) begin
                        if (r_q != '0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                            r_fim   <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (bus.carrega) begin
                        r_q <= bus.D;
                        if (r_state == ST_RUN && bus.D == '0) begin
                            r_state <= ST_DONE;
                            r_fim   <= 1'b1;
                        end
                    end else if (bus.pausa) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_state <= ST_RUN;
                        if (w_dec) begin
                            // Saturate: a zero Q reloaded while paused expires instead of wrapping.
                            if (r_q <= WIDTH'(1)) begin
                                r_q     <= '0;
                                r_state <= ST_DONE;
                                r_fim   <= 1'b1;
                            end else begin
                                r_q <= r_q - WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (bus.carrega) begin
                        r_q     <= bus.D;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.Q     = r_q;
    assign bus.ativo = is_active(r_state);
    assign bus.zero  = (r_q == '0);
    assign bus.fim   = r_fim;
endmodule

// File: doc/temporizador_regressivo.md
# temporizador_regressivo

Loadable down-counting timer with prescaler, pause and a one-cycle expiry pulse. It is the counting-down counterpart to the game's up-counters. The game FSM loads a time budget (e.g. the per-move limit), starts it, and receives `fim` when the budget is exhausted. `Q` is exposed so the display path can show the remaining time.

## Interface
- `WIDTH`, 16: counter width in bits.
- `PRESCALE`, 1: clock cycles per decrement; legal range 1 to 65535.

- `clock`  in  1  system clock, rising edge.
- `clr`  in  1  asynchronous active-low reset.
- `carrega`  in  1  synchronous load of `D` into `Q`, active-high.
- `inicia`  in  1  start request, sampled per cycle.
- `pausa`  in  1  level; freezes counting while high.
- `D`  in  WIDTH  load value.
- `Q`  out  WIDTH  remaining count, registered.
- `ativo`  out  1  high in RUN or PAUSE, registered state decode.
- `zero`  out  1  combinational, `Q == 0`.
- `fim`  out  1  registered one-cycle pulse on expiry.

## Operation
- Reset (`clr` = 0, asynchronous) forces:
  - `Q` = 0, state IDLE, prescaler = 0, `fim` = 0.
  - Outputs therefore read `ativo` = 0, `zero` = 1.
- States are IDLE, RUN, PAUSE, DONE. Priority within a cycle: `carrega` > `inicia` > `pausa` > count.
- IDLE:
  - `carrega`: `Q` ← `D`.
  - `inicia` with `carrega` = 0 and `Q` ≠ 0: go to RUN, prescaler ← 0.
  - `inicia` with `carrega` = 1 and `D` ≠ 0: `Q` ← `D` and go to RUN in the same edge.
  - `inicia` when the resulting `Q` would be 0: go to DONE, `fim` pulses.
- RUN:
  - `carrega`: `Q` ← `D`, prescaler ← 0, stay in RUN. If `D` = 0, go to DONE and pulse `fim`.
  - `pausa` = 1: go to PAUSE; prescaler and `Q` hold.
  - Otherwise the prescaler increments. When it equals `PRESCALE`−1 it wraps to 0 and `Q` ← `Q`−1.
  - A decrement from 1 to 0 moves to DONE and sets `fim` = 1 on that same edge.
- PAUSE:
  - `pausa` = 0: return to RUN and resume with the prescaler value it held.
  - `carrega`: `Q` ← `D`, prescaler ← 0, stay in PAUSE.
  - `inicia` is ignored.
- DONE:
  - `Q` holds 0 and `inicia` is ignored.
  - `carrega`: `Q` ← `D`, go to IDLE.
- Arithmetic and pulse rules:
  - `Q` never wraps below 0; there is no decrement in any state other than RUN.
  - `fim` is high for exactly one cycle per expiry.
  - `fim` is cleared on the following edge regardless of inputs.

## Timing
- With `inicia` sampled at edge k and `Q` = N ≠ 0, no pause and no reload:
  - Decrements occur at edges k+P, k+2P, …, k+N·P, where P = `PRESCALE`.
  - `fim` is high during the cycle after edge k+N·P.
- Each cycle `pausa` is high in RUN or PAUSE adds exactly one cycle of latency.
- Load latency is 1 edge; `Q` shows `D` in the cycle after `carrega`.
- `zero` follows `Q` combinationally with no added latency.
- `ativo` changes on the same edge as the state.
- Reset asserted mid-count aborts immediately and asynchronously. No `fim` is produced. Deassertion resumes in IDLE with `Q` = 0.

## Structure
- Shared package/include holds:
  - State encoding: IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11.
  - Default constants for `WIDTH` and `PRESCALE`.
- One sub-module, `divisor_tick`, holds the prescaler counter.
  - Inputs: `clock`, `clr`, synchronous clear, enable.
  - Output: one-cycle `tick` when the count reaches `PRESCALE`−1.
- The top level contains the FSM, the `Q` register and the `fim` register.

## Test plan
- Reset: assert `clr` mid-RUN with `Q` = 7 → next cycle `Q` = 0, `ativo` = 0, `zero` = 1, no `fim` pulse.
- Basic countdown (`PRESCALE` = 1): load `D` = 3, pulse `inicia` → `Q` reads 3, 2, 1, 0 on consecutive cycles; `fim` high exactly 1 cycle, coincident with `Q` = 0; state DONE.
- Prescaler (`PRESCALE` = 4): `D` = 2 → `fim` rises 8 cycles after the `inicia` edge; `Q` changes only every 4th cycle.
- Pause: `D` = 5, `pausa` high for 3 cycles mid-count → `fim` delayed by exactly 3 cycles; `Q` constant while paused; `ativo` stays 1.
- Edge cases:
  - `inicia` with `Q` = 0 → DONE plus one `fim` pulse.
  - `carrega` `D` = 9 during RUN at `Q` = 2 → restart from 9, no `fim`.
  - `carrega` with `inicia` in IDLE → RUN starting at `D`.
- DONE behaviour: `inicia` in DONE → no change. `carrega` `D` = 4 → IDLE with `Q` = 4, then a normal restart works.
